// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control stage.
// Provides the operation code enum, ALUOp and func7 encodings, the
// multi-cycle latency class enum and a helper that flags M-extension ops.
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'd0,
    OP_OR     = 5'd1,
    OP_ADD    = 5'd2,
    OP_XOR    = 5'd3,
    OP_SLL    = 5'd4,
    OP_SRL    = 5'd5,
    OP_SUB    = 5'd6,
    OP_SLT    = 5'd7,
    OP_SLTU   = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    LAT_SINGLE = 2'd0,
    LAT_MUL    = 2'd1,
    LAT_DIV    = 2'd2
  } lat_sel_e;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // M-extension codes all live in 16..23, so bit 4 identifies them.
  function automatic logic is_multicycle(input alu_op_e op);
    logic [4:0] bits;
    bits = op;
    return bits[4];
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decoder.
// Ports:
//   ALUOp_in  - instruction class (mem / branch / R-type / I-type)
//   func7     - instr[31:25]
//   func3     - instr[14:12]
//   op        - decoded operation code (ADD when illegal)
//   illegal   - decode failed
//   lat_sel   - occupancy class of the decoded op
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [1:0] ALUOp_in,
  input  logic [6:0] func7,
  input  logic [2:0] func3,
  output alu_op_e    op,
  output logic       illegal,
  output lat_sel_e   lat_sel
);

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    lat_sel = LAT_SINGLE;
    // func7/func3 are only examined inside the R/I branches, so X on them
    // during mem/branch ops never reaches op.
    case (ALUOp_in)
      ALUOP_MEM: op = OP_ADD;
      ALUOP_BR:  op = OP_SUB;
      ALUOP_R: begin
        if (func7 == F7_BASE) begin
          case (func3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (func7 == F7_ALT && func3 == 3'b000) begin
          op = OP_SUB;
        end else if (func7 == F7_ALT && func3 == 3'b101) begin
          op = OP_SRA;
        end else if (EN_M && func7 == F7_MULDIV) begin
          op = alu_op_e'({2'b10, func3});
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        case (func3)
          3'b000: op = OP_ADD;
          3'b001: begin
            if (func7 == F7_BASE) op = OP_SLL;
            else                  illegal = 1'b1;
          end
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: begin
            if (func7 == F7_BASE)     op = OP_SRL;
            else if (func7 == F7_ALT) op = OP_SRA;
            else                      illegal = 1'b1;
          end
          3'b110:  op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase

    if (illegal) op = OP_ADD;

    if (is_multicycle(op)) begin
      lat_sel = func3[2] ? LAT_DIV : LAT_MUL;
    end
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control stage between ID and EX.
// Decodes the incoming op, holds the code in an output register behind a
// valid/ready handshake and keeps EX occupied for multi-cycle MUL/DIV ops.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   valid_in/ready_out- upstream handshake
//   ALUOp_in/func7/func3 - decode inputs
//   flush             - synchronous flush, highest priority
//   valid_out/ready_in- downstream handshake
//   AluControl_out    - registered operation code
//   ctrl_busy         - multi-cycle op still counting
//   illegal_op        - registered decode-failure flag
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W     = 5,
  parameter bit          EN_M       = 1'b1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        ALUOp_in,
  input  logic [6:0]        func7,
  input  logic [2:0]        func3,
  input  logic              flush,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] AluControl_out,
  output logic              ctrl_busy,
  output logic              illegal_op
);

  localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e         code_q;
  logic            illegal_q;

  alu_op_e         dec_op;
  logic            dec_illegal;
  lat_sel_e        dec_lat_sel;
  logic [CNT_W-1:0] dec_lat;
  logic            accept;
  logic            load;
  logic [4:0]      code_bits;

  alu_op_decode #(
    .EN_M (EN_M)
  ) u_decode (
    .ALUOp_in (ALUOp_in),
    .func7    (func7),
    .func3    (func3),
    .op       (dec_op),
    .illegal  (dec_illegal),
    .lat_sel  (dec_lat_sel)
  );

  always_comb begin
    dec_lat = CNT_W'(1);
    case (dec_lat_sel)
      LAT_MUL: dec_lat = CNT_W'(MUL_CYCLES);
      LAT_DIV: dec_lat = CNT_W'(DIV_CYCLES);
      default: dec_lat = CNT_W'(1);
    endcase
  end

  assign ready_out = !flush && (state_q == IDLE || (state_q == HOLD && ready_in));
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: load = accept;
        HOLD: begin
          // ready_in in HOLD is exactly a downstream transfer.
          if (ready_in) begin
            if (accept) load = 1'b1;
            else        state_d = IDLE;
          end
        end
        BUSY: begin
          if (cnt_q <= CNT_W'(1)) state_d = HOLD;
          if (cnt_q != '0)        cnt_d = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
      if (load) begin
        if (dec_lat <= CNT_W'(1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          state_d = BUSY;
          cnt_d   = dec_lat - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= OP_ADD;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flush) begin
        illegal_q <= 1'b0;
      end else if (load) begin
        code_q    <= dec_op;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign code_bits      = code_q;
  assign AluControl_out = CTRL_W'(code_bits);
  assign valid_out      = (state_q != IDLE);
  assign ctrl_busy      = (state_q == BUSY);
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
module tb_alu_control_pipe;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [1:0] ALUOp_in;
  logic [6:0] func7;
  logic [2:0] func3;
  logic       flush;
  logic       ready_in;

  logic       ready_out, valid_out, ctrl_busy, illegal_op;
  logic [4:0] AluControl_out;
  logic       nm_ready_out, nm_valid_out, nm_ctrl_busy, nm_illegal_op;
  logic [4:0] nm_AluControl_out;

  int unsigned checks;
  int unsigned errors;

  alu_control_pipe #(
    .CTRL_W     (5),
    .EN_M       (1'b1),
    .MUL_CYCLES (2),
    .DIV_CYCLES (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .ALUOp_in       (ALUOp_in),
    .func7          (func7),
    .func3          (func3),
    .flush          (flush),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .AluControl_out (AluControl_out),
    .ctrl_busy      (ctrl_busy),
    .illegal_op     (illegal_op)
  );

  alu_control_pipe #(
    .CTRL_W     (5),
    .EN_M       (1'b0),
    .MUL_CYCLES (2),
    .DIV_CYCLES (32)
  ) dut_nm (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .ready_out      (nm_ready_out),
    .ALUOp_in       (ALUOp_in),
    .func7          (func7),
    .func3          (func3),
    .flush          (flush),
    .valid_out      (nm_valid_out),
    .ready_in       (ready_in),
    .AluControl_out (nm_AluControl_out),
    .ctrl_busy      (nm_ctrl_busy),
    .illegal_op     (nm_illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] code;
    logic       ill;
    logic       multi;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [6:0] f7v, input logic [2:0] f3v);
    valid_in = v;
    ALUOp_in = op;
    func7    = f7v;
    func3    = f3v;
  endtask

  // Let any pending op leave the stage with ready_in high.
  task automatic drain();
    int unsigned n;
    valid_in = 1'b0;
    ready_in = 1'b1;
    n = 0;
    while (valid_out && n < 100) begin
      tick();
      n++;
    end
    if (valid_out) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: valid_out=%0b expected 0", valid_out);
    end
  endtask

  task automatic add_vec(input logic [1:0] a, input logic [6:0] f7v, input logic [2:0] f3v,
                         input logic [4:0] c, input logic il, input logic m);
    vec_t v;
    v.aluop = a; v.f7 = f7v; v.f3 = f3v; v.code = c; v.ill = il; v.multi = m;
    vecs.push_back(v);
  endtask

  initial begin
    int unsigned n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    ready_in = 1'b1;
    drive(1'b0, 2'b00, 7'd0, 3'd0);

    add_vec(2'b00, 7'b1111111, 3'b111, 5'd2,  1'b0, 1'b0);
    add_vec(2'b01, 7'b1010101, 3'b011, 5'd6,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0000000, 3'b000, 5'd2,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0000000, 3'b001, 5'd4,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0000000, 3'b010, 5'd7,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0000000, 3'b011, 5'd8,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0000000, 3'b100, 5'd3,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0000000, 3'b101, 5'd5,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0100000, 3'b000, 5'd6,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0100000, 3'b101, 5'd9,  1'b0, 1'b0);
    add_vec(2'b10, 7'b0100000, 3'b111, 5'd2,  1'b1, 1'b0);
    add_vec(2'b10, 7'b0000010, 3'b000, 5'd2,  1'b1, 1'b0);
    add_vec(2'b10, 7'b0000001, 3'b000, 5'd16, 1'b0, 1'b1);
    add_vec(2'b10, 7'b0000001, 3'b011, 5'd19, 1'b0, 1'b1);
    add_vec(2'b10, 7'b0000001, 3'b101, 5'd21, 1'b0, 1'b1);
    add_vec(2'b10, 7'b0000001, 3'b111, 5'd23, 1'b0, 1'b1);
    add_vec(2'b11, 7'b1111111, 3'b000, 5'd2,  1'b0, 1'b0);
    add_vec(2'b11, 7'b0000000, 3'b001, 5'd4,  1'b0, 1'b0);
    add_vec(2'b11, 7'b0100000, 3'b001, 5'd2,  1'b1, 1'b0);
    add_vec(2'b11, 7'b0110011, 3'b011, 5'd8,  1'b0, 1'b0);
    add_vec(2'b11, 7'b0000000, 3'b101, 5'd5,  1'b0, 1'b0);
    add_vec(2'b11, 7'b0100000, 3'b101, 5'd9,  1'b0, 1'b0);
    add_vec(2'b11, 7'b0000001, 3'b101, 5'd2,  1'b1, 1'b0);
    add_vec(2'b11, 7'b0000000, 3'b110, 5'd1,  1'b0, 1'b0);

    // Reset state
    #12;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_code", 32'(AluControl_out), 32'd2);
    check("rst_busy", 32'(ctrl_busy), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_ready_out", 32'(ready_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Mem op with don't-care func fields
    @(negedge clk);
    drive(1'b1, 2'b00, 7'bx, 3'bx);
    tick();
    check("mem_valid", 32'(valid_out), 32'd1);
    check("mem_code", 32'(AluControl_out), 32'd2);
    check("mem_illegal", 32'(illegal_op), 32'd0);
    @(negedge clk);
    drain();

    // Decode table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].aluop, vecs[i].f7, vecs[i].f3);
      ready_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'd1);
      check($sformatf("vec%0d_code", i), 32'(AluControl_out), 32'(vecs[i].code));
      check($sformatf("vec%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
      check($sformatf("vec%0d_busy", i), 32'(ctrl_busy), 32'(vecs[i].multi));
      @(negedge clk);
      drain();
    end

    // Back-to-back SUB, AND, OR
    @(negedge clk);
    ready_in = 1'b1;
    drive(1'b1, 2'b10, 7'b0100000, 3'b000);
    tick();
    check("b2b_code0", 32'(AluControl_out), 32'd6);
    @(negedge clk);
    check("b2b_ready0", 32'(ready_out), 32'd1);
    drive(1'b1, 2'b10, 7'b0000000, 3'b111);
    tick();
    check("b2b_code1", 32'(AluControl_out), 32'd0);
    @(negedge clk);
    check("b2b_ready1", 32'(ready_out), 32'd1);
    drive(1'b1, 2'b10, 7'b0000000, 3'b110);
    tick();
    check("b2b_code2", 32'(AluControl_out), 32'd1);
    check("b2b_valid2", 32'(valid_out), 32'd1);
    @(negedge clk);
    drain();

    // DIV occupancy
    @(negedge clk);
    drive(1'b1, 2'b10, 7'b0000001, 3'b100);
    tick();
    valid_in = 1'b0;
    check("div_code", 32'(AluControl_out), 32'd20);
    n = 0;
    while (ctrl_busy && n < 100) begin
      if (ready_out) begin
        checks++;
        errors++;
        $display("FAIL div_ready_out: got 1 expected 0 at busy cycle %0d", n);
      end
      n++;
      tick();
    end
    check("div_busy_cycles", n, 32'd31);
    check("div_hold_valid", 32'(valid_out), 32'd1);
    check("div_hold_code", 32'(AluControl_out), 32'd20);
    tick();
    check("div_transfer", 32'(valid_out), 32'd0);

    // Stall holding SRA, then back-to-back accept of XOR
    @(negedge clk);
    ready_in = 1'b0;
    drive(1'b1, 2'b10, 7'b0100000, 3'b101);
    tick();
    drive(1'b1, 2'b10, 7'b0000000, 3'b100);
    for (int unsigned k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_valid", k), 32'(valid_out), 32'd1);
      check($sformatf("stall%0d_code", k), 32'(AluControl_out), 32'd9);
      check($sformatf("stall%0d_ready", k), 32'(ready_out), 32'd0);
      tick();
    end
    @(negedge clk);
    ready_in = 1'b1;
    #1;
    check("stall_release_ready", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    check("stall_next_valid", 32'(valid_out), 32'd1);
    check("stall_next_code", 32'(AluControl_out), 32'd3);
    @(negedge clk);
    drain();

    // Flush mid-DIV with a simultaneous valid_in
    @(negedge clk);
    drive(1'b1, 2'b10, 7'b0000001, 3'b100);
    tick();
    valid_in = 1'b0;
    repeat (21) tick();
    check("flush_pre_busy", 32'(ctrl_busy), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 2'b00, 7'd0, 3'd0);
    #1;
    check("flush_ready_out", 32'(ready_out), 32'd0);
    tick();
    flush = 1'b0;
    valid_in = 1'b0;
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_busy", 32'(ctrl_busy), 32'd0);
    check("flush_illegal", 32'(illegal_op), 32'd0);
    tick();
    check("flush_dropped", 32'(valid_out), 32'd0);

    // Async reset while holding an illegal op
    @(negedge clk);
    ready_in = 1'b0;
    drive(1'b1, 2'b11, 7'b0000001, 3'b101);
    tick();
    valid_in = 1'b0;
    check("hold_illegal", 32'(illegal_op), 32'd1);
    check("hold_valid", 32'(valid_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_out), 32'd0);
    check("async_rst_illegal", 32'(illegal_op), 32'd0);
    check("async_rst_code", 32'(AluControl_out), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    drive(1'b1, 2'b01, 7'd0, 3'd0);
    tick();
    valid_in = 1'b0;
    check("post_rst_accept", 32'(valid_out), 32'd1);
    check("post_rst_code", 32'(AluControl_out), 32'd6);
    @(negedge clk);
    drain();

    // EN_M=0 instance
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    drive(1'b1, 2'b10, 7'b0000001, 3'b000);
    tick();
    valid_in = 1'b0;
    check("nm_mul_illegal", 32'(nm_illegal_op), 32'd1);
    check("nm_mul_code", 32'(nm_AluControl_out), 32'd2);
    check("nm_mul_busy", 32'(nm_ctrl_busy), 32'd0);
    check("nm_mul_valid", 32'(nm_valid_out), 32'd1);
    @(negedge clk);
    drive(1'b1, 2'b11, 7'b0000001, 3'b101);
    tick();
    valid_in = 1'b0;
    check("nm_itype_illegal", 32'(nm_illegal_op), 32'd1);
    check("nm_itype_code", 32'(nm_AluControl_out), 32'd2);
    tick();
    check("nm_transfer", 32'(nm_valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
